// File: rtl/rand_burst_ctrl_pkg.sv
// Shared definitions for the randomizer burst sequencer: state encoding,
// seed width, pad byte and the seed-assembly helper.
package rand_burst_ctrl_pkg;

    localparam int SEED_W = 15;
    localparam logic [7:0] PAD_BYTE = 8'hFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PAD  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        DATA = ST_DATA,
        PAD  = ST_PAD,
        DONE = ST_DONE
    } state_t;

    // The 2'b11 and 1'b1 filler bits keep the seed from ever being all zeros.
    function automatic logic [SEED_W-1:0] build_seed(input logic [3:0] bsid,
                                                     input logic [3:0] diuc,
                                                     input logic [3:0] frame_num);
        return {bsid, 2'b11, diuc, 1'b1, frame_num};
    endfunction

endpackage

// File: rtl/rand_burst_ctrl_if.sv
// MAC byte-source handshake. A byte moves on every clock edge where
// src_valid && src_ready; src_data must be stable while src_valid is high.
interface rand_burst_ctrl_if;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;

    modport master (output src_data, output src_valid, input src_ready);
    modport slave  (input src_data, input src_valid, output src_ready);
endinterface

// File: rtl/rand_burst_ctrl_byte_ser.sv
// Byte-to-bit serializer: holds one byte and shifts it out MSB-first, one bit
// per cycle. ready is also high on the last bit so bytes can chain without a bubble.
module rand_byte_ser (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       ser_bit,
    output logic       valid,
    output logic       last
);
    logic [7:0] shreg;
    logic       held;
    logic [2:0] bit_cnt;

    assign last    = held && (bit_cnt == 3'd7);
    assign ready   = !held || last;
    assign valid   = held;
    assign ser_bit = held & shreg[7];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            held    <= 1'b0;
            bit_cnt <= '0;
        end else if (load && ready) begin
            shreg   <= data;
            held    <= 1'b1;
            bit_cnt <= '0;
        end else if (held) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (last) held <= 1'b0;
        end
    end
endmodule

// File: rtl/rand_burst_ctrl.sv
// Burst sequencer ahead of the bit-serial randomizer: seed reload, MAC byte
// serialization and (when RAND_BURST_CTRL_PAD_EN is defined) 0xFF padding.
module rand_burst_ctrl
    import rand_burst_ctrl_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [LEN_W-1:0]  alloc_len,
    input  logic [3:0]        bsid,
    input  logic [3:0]        diuc,
    input  logic [3:0]        frame_num,
    rand_burst_ctrl_if.slave  src,
    output logic              rnd_bits,
    output logic              rnd_valid,
    output logic              rnd_reload,
    output logic [SEED_W-1:0] rnd_iv,
    output logic              busy,
    output logic              done,
    output logic [2:0]        fsm_state
);
    state_t           state;
    state_t           tail_state;
    logic [LEN_W-1:0] data_len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic             ser_ready;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_last;
    logic             ready;
    logic             accept;
    logic             data_end;

    // Bytes are accepted from LOAD onward so the first bit can leave at T+2.
    assign ready      = (state == LOAD || state == DATA) && (byte_cnt < data_len_q) && ser_ready;
    assign src.src_ready = ready;
    assign accept     = src.src_valid && ready;
    assign data_end   = ser_last && (byte_cnt == data_len_q);

`ifdef RAND_BURST_CTRL_PAD_EN
    logic [LEN_W+2:0] pad_cnt;
    logic [LEN_W-1:0] eff_alloc;

    assign eff_alloc  = (alloc_len > data_len) ? alloc_len : data_len;
    assign tail_state = (pad_cnt != '0) ? PAD : DONE;
`else
    logic unused_alloc;

    assign unused_alloc = ^{alloc_len, PAD_BYTE};
    assign tail_state   = DONE;
`endif

    rand_byte_ser u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .data    (src.src_data),
        .ready   (ser_ready),
        .ser_bit (ser_bit),
        .valid   (ser_valid),
        .last    (ser_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data_len_q <= '0;
            byte_cnt   <= '0;
            rnd_iv     <= '0;
`ifdef RAND_BURST_CTRL_PAD_EN
            pad_cnt    <= '0;
`endif
        end else begin
            if (accept) byte_cnt <= byte_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_len_q <= data_len;
                        byte_cnt   <= '0;
                        rnd_iv     <= build_seed(bsid, diuc, frame_num);
`ifdef RAND_BURST_CTRL_PAD_EN
                        pad_cnt    <= {eff_alloc - data_len, 3'b000};
`endif
                        state      <= LOAD;
                    end
                end
                LOAD: state <= (data_len_q != '0) ? DATA : tail_state;
                DATA: if (data_end) state <= tail_state;
`ifdef RAND_BURST_CTRL_PAD_EN
                PAD: begin
                    pad_cnt <= pad_cnt - 1'b1;
                    if (pad_cnt == {{(LEN_W+2){1'b0}}, 1'b1}) state <= DONE;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rnd_valid = 1'b0;
        rnd_bits  = 1'b0;
        if (state == DATA) begin
            rnd_valid = ser_valid;
            rnd_bits  = ser_bit;
        end
`ifdef RAND_BURST_CTRL_PAD_EN
        else if (state == PAD) begin
            rnd_valid = 1'b1;
            rnd_bits  = PAD_BYTE[7];
        end
`endif
    end

    assign rnd_reload = (state == LOAD);
    assign busy       = (state == LOAD) || (state == DATA) || (state == PAD);
    assign done       = (state == DONE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_rand_burst_ctrl.sv
// Directed bench for rand_burst_ctrl: bit scoreboard fed from the source bytes,
// burst-level counters checked after every burst.
module tb_rand_burst_ctrl;
  import rand_burst_ctrl_pkg::*;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] data_len = '0;
  logic [LEN_W-1:0] alloc_len = '0;
  logic [3:0]       bsid = '0;
  logic [3:0]       diuc = '0;
  logic [3:0]       frame_num = '0;
  logic             rnd_bits;
  logic             rnd_valid;
  logic             rnd_reload;
  logic [14:0]      rnd_iv;
  logic             busy;
  logic             done;
  logic [2:0]       fsm_state;

  rand_burst_ctrl_if src ();

  rand_burst_ctrl #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_len   (data_len),
    .alloc_len  (alloc_len),
    .bsid       (bsid),
    .diuc       (diuc),
    .frame_num  (frame_num),
    .src        (src),
    .rnd_bits   (rnd_bits),
    .rnd_valid  (rnd_valid),
    .rnd_reload (rnd_reload),
    .rnd_iv     (rnd_iv),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];
  logic [7:0] src_bytes[$];
  int feed_gap = 0;
  bit feed_abort = 1'b0;

  int bits_seen, reload_cnt, done_cnt, accept_cnt, gap_cnt;
  int first_bit_cyc, last_bit_cyc, done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rnd_valid) begin
        check("bit_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rnd_bit", 32'(rnd_bits), 32'(exp_q.pop_front()));
        if (bits_seen == 0) first_bit_cyc = cyc;
        last_bit_cyc = cyc;
        bits_seen++;
      end
      if (rnd_reload) begin
        reload_cnt++;
        check("reload_excl", 32'(rnd_valid), 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (src.src_valid && src.src_ready) accept_cnt++;
      if (busy && !rnd_valid && !rnd_reload) gap_cnt++;
    end
  end

  // source driver
  task automatic feed();
    for (int i = 0; i < src_bytes.size() && !feed_abort; i++) begin
      int guard;
      if (i > 0 && feed_gap > 0) begin
        src.src_valid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!src.src_ready && guard < 200 && !feed_abort);
        repeat (feed_gap) @(posedge clk);
        #1;
      end
      src.src_data  = src_bytes[i];
      src.src_valid = 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end
      while (!src.src_ready && guard < 200 && !feed_abort);
      @(posedge clk);
      #1;
    end
    src.src_valid = 1'b0;
  endtask

  // burst driver: mid_at / rst_at are cycle offsets after the reload cycle, -1 = off
  task automatic run_burst(input int dl, input int al, input logic [3:0] b, input logic [3:0] d,
                           input logic [3:0] f, input int gap, input int mid_at, input int rst_at);
    int eff, exp_bits, t0;
    logic [14:0] seed;
    bit got_done, aborted;
    eff = (al > dl) ? al : dl;
`ifndef RAND_BURST_CTRL_PAD_EN
    eff = dl;
`endif
    exp_bits = 8 * eff;
    seed = {b, 2'b11, d, 1'b1, f};
    exp_q.delete();
    foreach (src_bytes[i]) for (int j = 7; j >= 0; j--) exp_q.push_back(src_bytes[i][j]);
    for (int j = 0; j < (eff - dl) * 8; j++) exp_q.push_back(1'b1);
    bits_seen = 0; reload_cnt = 0; done_cnt = 0; accept_cnt = 0; gap_cnt = 0;
    first_bit_cyc = -1; last_bit_cyc = -1; done_cyc = -1;
    feed_abort = 1'b0;
    feed_gap = gap;

    @(posedge clk); #1;
    data_len = dl[LEN_W-1:0]; alloc_len = al[LEN_W-1:0];
    bsid = b; diuc = d; frame_num = f;
    start = 1'b1;
    t0 = cyc;
    fork feed(); join_none
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_reload", 32'(rnd_reload), 32'd1);
    check("t1_valid", 32'(rnd_valid), 32'd0);
    check("t1_iv", 32'(rnd_iv), 32'(seed));
    check("t1_busy", 32'(busy), 32'd1);

    got_done = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 4000 && !got_done && !aborted; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
      end else if (k == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_outs", 32'({src.src_ready, rnd_bits, rnd_valid, rnd_reload, busy, done, fsm_state}), 32'd0);
        check("rst_iv", 32'(rnd_iv), 32'd0);
        feed_abort = 1'b1;
        aborted = 1'b1;
      end else if (k == mid_at) begin
        start = 1'b1;
        bsid = ~b;
        data_len = dl[LEN_W-1:0] + 11'd5;
      end else begin
        start = 1'b0;
      end
    end

    if (aborted) begin
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_idle", 32'({busy, fsm_state}), 32'd0);
      repeat (6) @(negedge clk);
    end else begin
      check("done_seen", 32'(got_done), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_start_ign", 32'({busy, rnd_reload, fsm_state}), 32'd0);
      check("bit_count", 32'(bits_seen), 32'(exp_bits));
      check("exp_empty", 32'(exp_q.size()), 32'd0);
      check("reload_cnt", 32'(reload_cnt), 32'd1);
      check("done_cnt", 32'(done_cnt), 32'd1);
      check("accept_cnt", 32'(accept_cnt), 32'(dl));
      check("gap_cnt", 32'(gap_cnt), 32'((dl > 1) ? gap * (dl - 1) : 0));
      check("iv_hold", 32'(rnd_iv), 32'(seed));
      if (exp_bits > 0) begin
        check("first_bit_lat", 32'(first_bit_cyc), 32'(t0 + 2));
        check("done_after_last", 32'(done_cyc), 32'(last_bit_cyc + 1));
      end else begin
        check("zero_done_lat", 32'(done_cyc), 32'(t0 + 2));
      end
    end
  endtask

  initial begin
    src.src_valid = 1'b0;
    src.src_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({src.src_ready, rnd_bits, rnd_valid, rnd_reload, busy, done, fsm_state}), 32'd0);
    check("reset_iv", 32'(rnd_iv), 32'd0);
    reset = 1'b0;

    // seed + data/pad
    src_bytes = '{8'hA5, 8'h3C};
    run_burst(2, 3, 4'hA, 4'h3, 4'h5, 0, -1, -1);
    check("seed_const", 32'(rnd_iv), 32'h5675);

    // starvation between bytes
    src_bytes = '{8'hC3, 8'h5A};
    run_burst(2, 2, 4'h1, 4'h2, 4'h3, 5, -1, -1);

    // clamp: allocation shorter than payload
    src_bytes = '{8'h81, 8'h7E, 8'h00};
    run_burst(3, 1, 4'hF, 4'h0, 4'h9, 0, -1, -1);

    // zero-length burst
    src_bytes.delete();
    run_burst(0, 0, 4'h6, 4'hC, 4'h0, 0, -1, -1);

    // start pulsed during DATA
    src_bytes = '{8'h12, 8'h34, 8'h56};
    run_burst(3, 5, 4'h4, 4'h4, 4'h4, 0, 8, -1);

    // payload 1, allocation 4
    src_bytes = '{8'hE7};
    run_burst(1, 4, 4'h2, 4'h8, 4'hB, 0, -1, -1);

    // reset in the middle of a burst (PAD when padding exists, DATA otherwise)
    src_bytes = '{8'hF0, 8'h0F, 8'hAA};
`ifdef RAND_BURST_CTRL_PAD_EN
    run_burst(3, 4, 4'h7, 4'h1, 4'h2, 0, -1, 28);
`else
    run_burst(3, 4, 4'h7, 4'h1, 4'h2, 0, -1, 11);
`endif

    // normal burst after reset
    src_bytes = '{8'h96, 8'h69};
    run_burst(2, 2, 4'h9, 4'h5, 4'hD, 0, -1, -1);

    // randomized bursts
    for (int r = 0; r < 4; r++) begin
      int dl, al, gap;
      dl  = $urandom_range(1, 4);
      al  = $urandom_range(0, 6);
      gap = $urandom_range(0, 2);
      src_bytes.delete();
      for (int i = 0; i < dl; i++) src_bytes.push_back(8'($urandom_range(0, 255)));
      run_burst(dl, al, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), gap, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_burst_ctrl.md
Name: rand_burst_ctrl

Overview:
- Burst sequencer in front of the bit-serial randomizer.
- Per burst: builds the 15-bit randomizer seed from BSID/DIUC/frame number, issues a one-cycle reload, then serialises MAC bytes MSB-first into the randomizer's bit/valid input.
- Fills the remaining allocation with 0xFF padding bytes.
- Sits between the MAC byte source and the randomizer, ahead of FEC.

Parameters:
- LEN_W, 11, width of byte-length fields (max burst 2047 bytes)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  burst start pulse; sampled in IDLE only
- data_len  in  LEN_W  MAC payload bytes for this burst; sampled on start
- alloc_len  in  LEN_W  allocated burst bytes (payload + pad); sampled on start
- bsid  in  4  base-station ID LSBs; sampled on start
- diuc  in  4  burst profile code; sampled on start
- frame_num  in  4  frame number LSBs; sampled on start
- src_data  in  8  MAC byte
- src_valid  in  1  src_data valid
- src_ready  out  1  byte accepted when src_valid && src_ready
- rnd_bits  out  1  serial bit to randomizer in_bits
- rnd_valid  out  1  to randomizer in_valid
- rnd_reload  out  1  to randomizer reload
- rnd_iv  out  15  to randomizer rand_iv
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last bit is issued

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and latched fields cleared. Reset mid-burst aborts immediately. No done pulse is generated for the aborted burst.
- Seed: rnd_iv = {bsid, 2'b11, diuc, 1'b1, frame_num}, from values latched on start. Held stable from LOAD until the next start.
- Effective allocation: eff_alloc = max(alloc_len, data_len), unsigned compare.
- FSM states: IDLE, LOAD, DATA, PAD, DONE.
- IDLE:
  - busy=0.
  - start=1 latches inputs, sets busy=1, goes to LOAD.
- LOAD:
  - Exactly one cycle, rnd_reload=1, rnd_valid=0.
  - Next state is DATA if data_len>0.
  - Else PAD if eff_alloc>0.
  - Else DONE.
- DATA:
  - Internal 8-bit shift register, a held flag and a 3-bit bit counter.
  - src_ready=1 when bytes_accepted<data_len AND (held=0 OR bit_cnt==7 this cycle). This allows back-to-back bytes with no bubble.
  - While held: rnd_valid=1, rnd_bits=shreg[7], shift left, bit_cnt++.
  - When held=0 (source starved): rnd_valid=0 and rnd_bits=0. The randomizer holds its state.
  - After the last bit of byte data_len: go to PAD if eff_alloc>data_len, else DONE.
- PAD:
  - rnd_valid=1, rnd_bits=1 continuously, with no stalls.
  - Emits (eff_alloc-data_len)*8 bits, then goes to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored; this includes start in the DONE cycle.
- rnd_reload and rnd_valid are never high together.
- Latency: start at cycle T gives reload at T+1 and the first possible data bit at T+2.
- Total rnd_valid bits per burst = 8*eff_alloc exactly.
- Byte counter is LEN_W bits wide and never wraps, since lengths are bounded by LEN_W.

Optional Feature:
- Macro: RAND_BURST_CTRL_PAD_EN.
- Defined: PAD state and eff_alloc logic exist as above.
- Undefined:
  - alloc_len is ignored and PAD is removed.
  - DATA goes directly to DONE.
  - LOAD with data_len==0 goes directly to DONE.
  - Total bits = 8*data_len.

Decomposition:
- Shared package holds:
  - FSM state encoding: 3-bit localparams for IDLE/LOAD/DATA/PAD/DONE.
  - SEED_W=15.
  - PAD_BYTE=8'hFF.
  - A seed-build function taking bsid/diuc/frame_num.
- One natural sub-module: rand_byte_ser.
  - Contents: shift register, held flag, bit counter.
  - Interface: load/ready/bit/valid ports; ready asserted on the last bit.
- FSM and byte counters stay in the top level.

Test Plan:
- Seed: start with bsid=4'hA, diuc=4'h3, frame_num=4'h5 -> rnd_iv=15'h5675, rnd_reload=1 exactly one cycle (T+1), rnd_valid=0 that cycle.
- Data + pad: data_len=2, alloc_len=3, source always valid with 0xA5,0x3C -> 24 consecutive rnd_valid bits 10100101_00111100_11111111 from T+2, src_ready pulses twice, done one cycle after the last bit.
- Starvation: data_len=2, src_valid dropped 5 cycles between bytes -> rnd_valid low exactly 5 cycles, bit sequence unchanged, no reload.
- Clamp/zero: data_len=3, alloc_len=1 -> 24 bits, no pad; data_len=0, alloc_len=0 -> reload then done at T+2, zero rnd_valid.
- Ignored start and reset: start pulsed during DATA -> no effect on counts. reset asserted mid-PAD -> all outputs 0 immediately, no done, next start behaves normally.
- Macro off: data_len=1, alloc_len=4 -> exactly 8 bits, then done.
